fetch_ctrl: RTL and testbench

- Sequencing controller for the RV32I fetch stage.
- Decides when the PC register advances, issues instruction-memory requests (valid/ready) and tracks outstanding requests.
- Pairs each in-order response with its PC and buffers it in a small FIFO toward decode.
- On branch/jump redirect, flushes buffered and in-flight instructions. On PC overflow error, halts fetch.

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/fctl_fifo.sv | 62 ++++++
 rtl/fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the RV32I fetch sequencing controller.
// Holds the controller state encoding, the {pc, instr} entry used by both
// the decode buffer and the in-flight PC queue, and the PC increment.
package fetch_ctrl_pkg;

  localparam int FCTL_XLEN = 32;
  localparam logic [FCTL_XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fctl_state_e;

  typedef struct packed {
    logic [FCTL_XLEN-1:0] pc;
    logic [FCTL_XLEN-1:0] instr;
  } fctl_entry_t;

endpackage

// File: rtl/fctl_fifo.sv
// Small synchronous FIFO of fctl_entry_t with first-word fall-through read,
// a synchronous flush that empties it on the next edge, and count/full/empty.
// Used both as the decode buffer and as the in-flight PC queue.
module fctl_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  fctl_entry_t push_data,
  input  logic        pop,
  output fctl_entry_t pop_data,
  output logic [CW-1:0] count,
  output logic        full,
  output logic        empty
);

  fctl_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only visible through count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: issues imem requests under a credit
// scheme, pairs in-order responses with their PCs, buffers them toward
// decode, flushes on redirect and halts on PC overflow.
// Optional macro FETCH_CTRL_PERF_CNT_EN adds saturating performance counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int XLEN      = FCTL_XLEN,
  parameter int BUF_DEPTH = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic            fctl_clk,
  input  logic            fctl_rst,
  input  logic            fetch_en,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_error,
  output logic            pc_adv,
  input  logic            redir_valid,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic            halted
`ifdef FETCH_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall
`endif
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int BW = $clog2(BUF_DEPTH + 1);

  fctl_state_e state;
  fctl_state_e state_nxt;

  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic          credit;
  logic          would_issue;
  logic          issue;
  logic          rsp_drop;
  logic          fifo_push;
  logic          dec_pop;

  fctl_entry_t   pcq_head;
  fctl_entry_t   pcq_in;
  logic [OW-1:0] pcq_count;
  logic          pcq_full;
  logic          pcq_empty;

  fctl_entry_t   fifo_in;
  fctl_entry_t   fifo_head;
  logic [BW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  logic          unused_sigs;

  assign credit = (int'(outstanding) < MAX_OUTST) &&
                  ((int'(outstanding) + int'(fifo_count)) < BUF_DEPTH);
  assign would_issue    = (state == RUN) && credit && !redir_valid;
  assign imem_req_valid = would_issue && !pc_error;
  assign imem_req_addr  = imem_req_valid ? pc_in : '0;
  assign issue          = imem_req_valid && imem_req_ready;
  assign pc_adv         = issue || redir_valid;

  // Responses belonging to flushed requests are dropped; their PCs were
  // already flushed from the queue, so only kept responses pop it.
  assign rsp_drop  = imem_rsp_valid && (redir_valid || (drop_cnt != '0));
  assign fifo_push = imem_rsp_valid && !rsp_drop;

  assign pcq_in    = '{pc: pc_in, instr: '0};
  assign fifo_in   = '{pc: pcq_head.pc, instr: imem_rsp_data};

  assign dec_valid = !fifo_empty;
  assign dec_pop   = dec_valid && dec_ready;
  assign dec_instr = fifo_empty ? '0 : fifo_head.instr;
  assign dec_pc    = fifo_empty ? '0 : fifo_head.pc;
  assign halted    = (state == HALT);

  assign unused_sigs = ^{pcq_count, pcq_full, pcq_empty, fifo_full, pcq_head.instr};

  fctl_fifo #(.DEPTH(MAX_OUTST)) u_pc_queue (
    .clk       (fctl_clk),
    .rst_n     (fctl_rst),
    .flush     (redir_valid),
    .push      (issue),
    .push_data (pcq_in),
    .pop       (fifo_push),
    .pop_data  (pcq_head),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  fctl_fifo #(.DEPTH(BUF_DEPTH)) u_dec_fifo (
    .clk       (fctl_clk),
    .rst_n     (fctl_rst),
    .flush     (redir_valid),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (dec_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Controller state register.
  always_ff @(posedge fctl_clk or negedge fctl_rst) begin
    if (!fctl_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next state: an overflow seen when a request would go out halts for good.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_en) state_nxt = RUN;
      RUN: begin
        if (pc_error && would_issue) state_nxt = HALT;
        else if (!fetch_en)          state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // In-flight request count and the number of stale responses still to drop.
  always_ff @(posedge fctl_clk or negedge fctl_rst) begin
    if (!fctl_rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(issue) - OW'(imem_rsp_valid);
      if (redir_valid)
        drop_cnt <= outstanding - OW'(imem_rsp_valid);
      else if (imem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - 1'b1;
    end
  end

`ifdef FETCH_CTRL_PERF_CNT_EN
  // Saturating counters for buffered, dropped and credit-stalled cycles.
  always_ff @(posedge fctl_clk or negedge fctl_rst) begin
    if (!fctl_rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (fifo_push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 1'b1;
      if (rsp_drop && (perf_dropped != '1))  perf_dropped <= perf_dropped + 1'b1;
      if ((state == RUN) && !credit && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl. The bench plays the PC
// register (pc+4 on issue, target on redirect) and an in-order imem whose
// responses are either automatic (one cycle after issue) or hand-driven.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        fctl_clk = 1'b0;
  logic        fctl_rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_error = 1'b0;
  logic        pc_adv;
  logic        redir_valid = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        halted;
`ifdef FETCH_CTRL_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
  logic [31:0] perf_stall;
`endif

  int          total = 0;
  int          bad = 0;
  int          issue_cnt = 0;
  bit          auto_rsp = 1'b0;
  logic [31:0] redir_target = '0;
  logic [31:0] rsp_q [$];

  fetch_ctrl dut (
    .fctl_clk       (fctl_clk),
    .fctl_rst       (fctl_rst),
    .fetch_en       (fetch_en),
    .pc_in          (pc_in),
    .pc_error       (pc_error),
    .pc_adv         (pc_adv),
    .redir_valid    (redir_valid),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .halted         (halted)
`ifdef FETCH_CTRL_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped),
    .perf_stall     (perf_stall)
`endif
  );

  // Free-running clock.
  always #5 fctl_clk = ~fctl_clk;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample the handshake, take the edge, update PC and imem models.
  task automatic applyStimulus();
    logic        was_issue;
    logic        was_adv;
    logic        was_redir;
    logic [31:0] a;
    #1;
    was_issue = imem_req_valid && imem_req_ready;
    was_adv   = pc_adv;
    was_redir = redir_valid;
    a         = imem_req_addr;
    @(posedge fctl_clk);
    #1;
    if (was_issue) begin
      rsp_q.push_back(a);
      issue_cnt++;
    end
    if (was_adv) pc_in = was_redir ? redir_target : pc_in + PC_STEP;
    redir_valid    = 1'b0;
    imem_rsp_valid = 1'b0;
    if (auto_rsp && (rsp_q.size() > 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(rsp_q.pop_front());
    end
    #1;
  endtask

  // Hand-drive the oldest pending response in the current cycle.
  task automatic driveRsp();
    if (rsp_q.size() == 0) begin
      checkOutput("rsp_pending", 32'd0, 32'd1);
    end else begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(rsp_q.pop_front());
    end
  endtask

  task automatic applyReset(input logic [31:0] pc0);
    fctl_rst       = 1'b0;
    fetch_en       = 1'b0;
    pc_error       = 1'b0;
    redir_valid    = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    auto_rsp       = 1'b0;
    rsp_q.delete();
    pc_in          = pc0;
    issue_cnt      = 0;
    @(posedge fctl_clk);
    @(posedge fctl_clk);
    #2;
    fctl_rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #1 fctl_rst = 1'b0;
    #2;
    checkOutput("rst_dec_valid", dec_valid, 0);
    checkOutput("rst_req_valid", imem_req_valid, 0);
    checkOutput("rst_req_addr", imem_req_addr, 0);
    checkOutput("rst_pc_adv", pc_adv, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_dec_pc", dec_pc, 0);
    checkOutput("rst_dec_instr", dec_instr, 0);

    // Streaming fetch, 1-cycle imem, decode always ready
    applyReset(32'h0);
    fetch_en = 1'b1;
    auto_rsp = 1'b1;
    #1;
    checkOutput("t1_idle_req", imem_req_valid, 0);
    applyStimulus();
    checkOutput("t1_c1_req", imem_req_valid, 1);
    checkOutput("t1_c1_addr", imem_req_addr, 32'h0);
    applyStimulus();
    checkOutput("t1_c2_addr", imem_req_addr, 32'h4);
    checkOutput("t1_c2_dec_valid", dec_valid, 0);
    applyStimulus();
    checkOutput("t1_c3_dec_valid", dec_valid, 1);
    checkOutput("t1_c3_dec_pc", dec_pc, 32'h0);
    checkOutput("t1_c3_dec_instr", dec_instr, instr_of(32'h0));
    applyStimulus();
    checkOutput("t1_c4_dec_pc", dec_pc, 32'h4);
    checkOutput("t1_c4_dec_instr", dec_instr, instr_of(32'h4));
    applyStimulus();
    checkOutput("t1_c5_dec_pc", dec_pc, 32'h8);
    checkOutput("t1_c5_dec_instr", dec_instr, instr_of(32'h8));
    fetch_en = 1'b0;
    repeat (6) applyStimulus();
    checkOutput("t1_drained", dec_valid, 0);
    checkOutput("t1_stopped", imem_req_valid, 0);

    // Decode stalled: buffer credit limits issue to BUF_DEPTH
    applyReset(32'h100);
    fetch_en  = 1'b1;
    dec_ready = 1'b0;
    auto_rsp  = 1'b1;
    repeat (10) applyStimulus();
    checkOutput("t2_issue_cnt", issue_cnt, 4);
    checkOutput("t2_req_blocked", imem_req_valid, 0);
    checkOutput("t2_dec_valid", dec_valid, 1);
    checkOutput("t2_dec_pc_hold", dec_pc, 32'h100);
    checkOutput("t2_dec_instr_hold", dec_instr, instr_of(32'h100));
    dec_ready = 1'b1;
    applyStimulus();
    checkOutput("t2_resume_req", imem_req_valid, 1);
    checkOutput("t2_resume_pc", dec_pc, 32'h104);
    fetch_en = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("t2_drained", dec_valid, 0);

    // Redirect with two requests in flight: both responses dropped
    applyReset(32'h10);
    fetch_en = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("t3_outst_full", imem_req_valid, 0);
    redir_valid  = 1'b1;
    redir_target = 32'h80;
    #1;
    checkOutput("t3_redir_adv", pc_adv, 1);
    applyStimulus();
    driveRsp();
    #1;
    checkOutput("t3_drop1_dec", dec_valid, 0);
    applyStimulus();
    driveRsp();
    auto_rsp = 1'b1;
    #1;
    checkOutput("t3_target_req", imem_req_valid, 1);
    checkOutput("t3_target_addr", imem_req_addr, 32'h80);
    applyStimulus();
    checkOutput("t3_drop2_dec", dec_valid, 0);
    applyStimulus();
    checkOutput("t3_target_valid", dec_valid, 1);
    checkOutput("t3_target_pc", dec_pc, 32'h80);
    checkOutput("t3_target_instr", dec_instr, instr_of(32'h80));
    fetch_en = 1'b0;
    repeat (8) applyStimulus();

    // Redirect coincident with a response: one remaining drop
    applyReset(32'h20);
    fetch_en = 1'b1;
    repeat (3) applyStimulus();
    driveRsp();
    redir_valid  = 1'b1;
    redir_target = 32'h200;
    #1;
    checkOutput("t4_redir_noreq", imem_req_valid, 0);
    applyStimulus();
    checkOutput("t4_target_req", imem_req_valid, 1);
    checkOutput("t4_target_addr", imem_req_addr, 32'h200);
    checkOutput("t4_flush_dec", dec_valid, 0);
    applyStimulus();
    driveRsp();
    auto_rsp = 1'b1;
    #1;
    checkOutput("t4_drop_dec", dec_valid, 0);
    applyStimulus();
    checkOutput("t4_dropped", dec_valid, 0);
    applyStimulus();
    checkOutput("t4_target_valid", dec_valid, 1);
    checkOutput("t4_target_pc", dec_pc, 32'h200);
    fetch_en = 1'b0;
    repeat (8) applyStimulus();

    // PC overflow halts fetch; pending response still delivered
    applyReset(32'h40);
    fetch_en = 1'b1;
    repeat (2) applyStimulus();
    pc_in    = 32'hFFFF_FFFC;
    pc_error = 1'b1;
    #1;
    checkOutput("t5_err_noreq", imem_req_valid, 0);
    checkOutput("t5_err_noadv", pc_adv, 0);
    checkOutput("t5_not_yet_halted", halted, 0);
    applyStimulus();
    checkOutput("t5_halted", halted, 1);
    pc_error = 1'b0;
    #1;
    checkOutput("t5_halt_noreq", imem_req_valid, 0);
    fetch_en = 1'b0;
    applyStimulus();
    fetch_en = 1'b1;
    applyStimulus();
    checkOutput("t5_halt_sticky", halted, 1);
    checkOutput("t5_halt_sticky_req", imem_req_valid, 0);
    driveRsp();
    applyStimulus();
    checkOutput("t5_late_valid", dec_valid, 1);
    checkOutput("t5_late_pc", dec_pc, 32'h40);
    checkOutput("t5_late_instr", dec_instr, instr_of(32'h40));
    applyStimulus();
    checkOutput("t5_late_drained", dec_valid, 0);

    // Asynchronous reset mid-stream
    applyReset(32'h300);
    fetch_en  = 1'b1;
    dec_ready = 1'b0;
    auto_rsp  = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("t6_busy", dec_valid, 1);
    #2;
    fctl_rst = 1'b0;
    #1;
    checkOutput("t6_async_dec_valid", dec_valid, 0);
    checkOutput("t6_async_req_valid", imem_req_valid, 0);
    checkOutput("t6_async_pc_adv", pc_adv, 0);
    checkOutput("t6_async_dec_pc", dec_pc, 0);
    checkOutput("t6_async_dec_instr", dec_instr, 0);
    checkOutput("t6_async_req_addr", imem_req_addr, 0);
    rsp_q.delete();
    auto_rsp       = 1'b0;
    imem_rsp_valid = 1'b0;
    fetch_en       = 1'b0;
    #1;
    fctl_rst = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("t6_idle_req", imem_req_valid, 0);
    checkOutput("t6_idle_halted", halted, 0);
    fetch_en = 1'b1;
    applyStimulus();
    checkOutput("t6_run_req", imem_req_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
